mult_req_arbiter: RTL and testbench

- Shares the single 8x8 sequential multiplier datapath between two independent requesters.
- Arbitrates round-robin and registers the winner's operands onto the multiplier's a/b inputs.
- Pulses the multiplier's start, waits for its done_flag, and returns the 16-bit product to the granted requester with a one-cycle valid.
- Sits between the requesting logic and the multiplier top level.
- Includes a watchdog so a hung multiplier cannot lock out both requesters.

---
 rtl/mult_req_arbiter_pkg.sv | 13 +
 rtl/mult_req_arbiter_if.sv | 15 +
 rtl/mult_req_arbiter_rr_arb2.sv | 11 +
 rtl/mult_req_arbiter.sv | 77 +++++++
 tb/tb_mult_req_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_req_arbiter_pkg.sv
// mult_arb_pkg: shared FSM encoding, width default and requester indices for the multiplier arbiter.
package mult_arb_pkg;
  localparam int DW_DEF = 8;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/mult_req_arbiter_if.sv
// mult_req_arbiter_if: requester handshakes and multiplier port bundle shared by arbiter and its environment.
interface mult_req_arbiter_if import mult_arb_pkg::*; #(parameter int DW = DW_DEF);
  logic          req0, req1, gnt0, gnt1, res_valid0, res_valid1;
  logic          m_start, m_done, busy, timeout_err;
  logic [DW-1:0] a0, b0, a1, b1, m_a, m_b;
  logic [2*DW-1:0] res0, res1, m_result;
  modport master (
    output req0, a0, b0, req1, a1, b1, m_done, m_result,
    input  gnt0, gnt1, res_valid0, res_valid1, res0, res1, m_a, m_b, m_start, busy, timeout_err
  );
  modport slave (
    input  req0, a0, b0, req1, a1, b1, m_done, m_result,
    output gnt0, gnt1, res_valid0, res_valid1, res0, res1, m_a, m_b, m_start, busy, timeout_err
  );
endinterface

// File: rtl/mult_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_winner,
  output logic o_any
);
  assign o_any    = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/mult_req_arbiter.sv
// mult_req_arbiter: shares one sequential multiplier between two requesters with round-robin and a watchdog.
module mult_req_arbiter import mult_arb_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mult_req_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "TIMEOUT must be nonzero");
  end
  state_t          r_state, w_next;
  logic            r_owner, r_last, r_to;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_ma, r_mb;
  logic [2*DW-1:0] r_res0, r_res1;
  logic            w_win, w_any, w_done_q, w_tmo;
  logic [2*DW-1:0] w_res;
  rr_arb2 u_arb (
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_any    (w_any)
  );
  // done seen in the first WAIT cycle may be left over from the previous operation
  assign w_done_q = (r_state == WAIT) && (r_cnt != '0) && bus.m_done;
  assign w_tmo    = (r_state == WAIT) && !w_done_q && (r_cnt == CW'(TIMEOUT - 1));
  assign w_res    = w_tmo ? '0 : bus.m_result;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (w_any ? LOAD : IDLE) :
             (r_state == LOAD)  ? START :
             (r_state == START) ? WAIT :
             (r_state == WAIT)  ? ((w_done_q || w_tmo) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_owner <= REQ0;
      r_last  <= REQ1;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_res0  <= '0;
      r_res1  <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_ma    <= w_win ? bus.a1 : bus.a0;
        r_mb    <= w_win ? bus.b1 : bus.b0;
      end
      r_cnt <= (r_state == START) ? '0 : (r_state == WAIT) ? r_cnt + CW'(1) : r_cnt;
      if (w_done_q || w_tmo) begin
        r_last <= r_owner;
        r_to   <= w_tmo;
        if (r_owner == REQ1) r_res1 <= w_res;
        else                 r_res0 <= w_res;
      end
    end
  assign bus.gnt0        = (r_state == LOAD) && (r_owner == REQ0);
  assign bus.gnt1        = (r_state == LOAD) && (r_owner == REQ1);
  assign bus.res_valid0  = (r_state == RESP) && (r_owner == REQ0);
  assign bus.res_valid1  = (r_state == RESP) && (r_owner == REQ1);
  assign bus.timeout_err = (r_state == RESP) && r_to;
  assign bus.m_start     = (r_state == START);
  assign bus.busy        = (r_state != IDLE);
  assign bus.m_a         = r_ma;
  assign bus.m_b         = r_mb;
  assign bus.res0        = r_res0;
  assign bus.res1        = r_res1;
endmodule

// File: tb/tb_mult_req_arbiter.sv
// tb_mult_req_arbiter: scenario tasks with a result scoreboard and a behavioural multiplier model.
module tb_mult_req_arbiter;
  import mult_arb_pkg::*;
  localparam int DW = 8;
  typedef struct {
    logic        who;
    logic [15:0] res;
    logic        to;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mult_req_arbiter_if #(.DW(DW)) bus ();
  mult_req_arbiter #(.DW(DW), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_r0 = '0;
  logic [15:0] exp_r1 = '0;
  int          lat = 12;
  bit          hang = 1'b0;
  bit          stale = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_prod = '0;
  logic [54:0] outs;
  assign outs = {bus.gnt0, bus.gnt1, bus.res_valid0, bus.res_valid1, bus.res0, bus.res1,
                 bus.m_a, bus.m_b, bus.m_start, bus.busy, bus.timeout_err};
  // multiplier model: done is a level that stays high until after the next start
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_cnt        <= 0;
      bus.m_done   <= 1'b0;
      bus.m_result <= '0;
    end else if (bus.m_start) begin
      m_cnt  <= lat;
      m_prod <= 16'(bus.m_a) * 16'(bus.m_b);
      if (!stale) bus.m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !hang) begin
        bus.m_done   <= 1'b1;
        bus.m_result <= m_prod;
      end else bus.m_done <= 1'b0;
    end
  always @(negedge clk) begin
    exp_t        e;
    logic        who;
    logic [15:0] got, oth, oth_exp;
    if (rst) begin
      exp_r0 = '0;
      exp_r1 = '0;
    end
    if (bus.gnt0 || bus.gnt1) begin
      checks++;
      if (bus.gnt0 && bus.gnt1) begin
        errors++;
        $display("FAIL gnt_overlap: gnt0=%b gnt1=%b, required at most one", bus.gnt0, bus.gnt1);
      end
    end
    if (bus.res_valid0 || bus.res_valid1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: res_valid0=%b res_valid1=%b with nothing pending", bus.res_valid0, bus.res_valid1);
      end else begin
        e       = sb.pop_front();
        who     = bus.res_valid1;
        got     = who ? bus.res1 : bus.res0;
        oth     = who ? bus.res0 : bus.res1;
        oth_exp = who ? exp_r0 : exp_r1;
        if ({bus.res_valid0 & bus.res_valid1, who, got, bus.timeout_err, oth} !== {1'b0, e.who, e.res, e.to, oth_exp}) begin
          errors++;
          $display("FAIL result: got who=%0d res=%h tmo=%b other=%h, required who=%0d res=%h tmo=%b other=%h",
                   who, got, bus.timeout_err, oth, e.who, e.res, e.to, oth_exp);
        end
        if (e.who) exp_r1 = e.res;
        else       exp_r0 = e.res;
      end
    end
  end
  task automatic test_reset();
    {bus.req0, bus.req1, bus.a0, bus.b0, bus.a1, bus.b1} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_no_req: got %h, required 0", outs);
    end
  endtask
  task automatic test_single();
    int n;
    logic prev;
    lat = 12;
    prev = 1'b0;
    bus.a0 = 8'd12; bus.b0 = 8'd13; bus.req0 = 1'b1;
    sb.push_back('{1'b0, 16'h009C, 1'b0});
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.m_a, bus.m_b, bus.busy} !== {1'b1, 1'b0, 8'd12, 8'd13, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b m_a=%0d m_b=%0d busy=%b, required 1 0 12 13 1",
               bus.gnt0, bus.gnt1, bus.m_a, bus.m_b, bus.busy);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.m_start, bus.gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL single_start: m_start=%b gnt0=%b, required 1 0", bus.m_start, bus.gnt0);
    end
    for (n = 0; n < 100 && !bus.res_valid0; n++) begin
      prev = bus.m_done;
      @(negedge clk);
    end
    checks++;
    if (n != lat + 2 || prev !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: cycles=%0d done_before=%b, required %0d 1", n, prev, lat + 2);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.res_valid0, bus.res0, bus.res1} !== {2'b00, 16'h009C, 16'h0000}) begin
      errors++;
      $display("FAIL single_after: busy=%b rv0=%b res0=%h res1=%h, required 0 0 009c 0000",
               bus.busy, bus.res_valid0, bus.res0, bus.res1);
    end
  endtask
  task automatic test_simultaneous();
    int n, got;
    lat = 6;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got = 0;
    bus.a0 = 8'd255; bus.b0 = 8'd255; bus.a1 = 8'd3; bus.b1 = 8'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sb.push_back('{1'b0, 16'hFE01, 1'b0});
    sb.push_back('{1'b1, 16'h000F, 1'b0});
    for (n = 0; n < 200 && (bus.req0 || bus.req1); n++) begin
      @(negedge clk);
      if (bus.gnt0) begin got = got * 10 + 1; bus.req0 = 1'b0; end
      if (bus.gnt1) begin got = got * 10 + 2; bus.req1 = 1'b0; end
    end
    checks++;
    if (got != 12) begin
      errors++;
      $display("FAIL simul_order: grant code=%0d, required 12", got);
    end
    for (n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simul_drain: pending=%0d, required 0", sb.size());
    end
  endtask
  task automatic test_stale_done();
    int n;
    stale = 1'b1;
    lat = 6;
    @(negedge clk);
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.req0 = 1'b1;
    sb.push_back('{1'b0, 16'h003F, 1'b0});
    @(negedge clk);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.m_done, bus.busy, bus.res_valid0} !== 3'b110) begin
      errors++;
      $display("FAIL stale_first_wait: m_done=%b busy=%b rv0=%b, required 1 1 0", bus.m_done, bus.busy, bus.res_valid0);
    end
    for (n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stale_drain: pending=%0d, required 0", sb.size());
    end
    stale = 1'b0;
  endtask
  task automatic test_timeout();
    int n;
    hang = 1'b1;
    lat = 6;
    @(negedge clk);
    bus.a1 = 8'd2; bus.b1 = 8'd2; bus.req1 = 1'b1;
    sb.push_back('{1'b1, 16'h0000, 1'b1});
    @(negedge clk);
    checks++;
    if (bus.gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_grant: gnt1=%b, required 1", bus.gnt1);
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    for (n = 0; n < 100 && !bus.res_valid1; n++) @(negedge clk);
    checks++;
    if (n != 16 || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_latency: cycles=%0d timeout_err=%b, required 16 1", n, bus.timeout_err);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.timeout_err, bus.res_valid1} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b timeout_err=%b rv1=%b, required 0 0 0", bus.busy, bus.timeout_err, bus.res_valid1);
    end
    hang = 1'b0;
  endtask
  task automatic test_reset_mid_wait();
    int n, got, seen;
    lat = 10;
    bus.a0 = 8'd9; bus.b0 = 8'd9; bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.res_valid0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: res_valid0 count=%0d, required 0", seen);
    end
    lat = 4;
    got = 0;
    bus.a0 = 8'd1; bus.b0 = 8'd2; bus.a1 = 8'd3; bus.b1 = 8'd4;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sb.push_back('{1'b0, 16'd2, 1'b0});
    sb.push_back('{1'b1, 16'd12, 1'b0});
    for (n = 0; n < 200 && (bus.req0 || bus.req1); n++) begin
      @(negedge clk);
      if (bus.gnt0) begin got = got * 10 + 1; bus.req0 = 1'b0; end
      if (bus.gnt1) begin got = got * 10 + 2; bus.req1 = 1'b0; end
    end
    checks++;
    if (got != 12) begin
      errors++;
      $display("FAIL reset_tie_order: grant code=%0d, required 12", got);
    end
    for (n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_tie_drain: pending=%0d, required 0", sb.size());
    end
  endtask
  task automatic test_fairness();
    int n, got, c0, c1;
    lat = 3;
    got = 0; c0 = 0; c1 = 0;
    @(negedge clk);
    bus.a0 = 8'd20; bus.b0 = 8'd30; bus.a1 = 8'd40; bus.b1 = 8'd50;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sb.push_back('{1'b0, 16'd600, 1'b0});
    sb.push_back('{1'b1, 16'd2000, 1'b0});
    sb.push_back('{1'b0, 16'd4200, 1'b0});
    sb.push_back('{1'b1, 16'd7200, 1'b0});
    for (n = 0; n < 400 && (bus.req0 || bus.req1); n++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        got = got * 10 + 1;
        c0++;
        if (c0 == 1) begin bus.a0 = 8'd60; bus.b0 = 8'd70; end
        else bus.req0 = 1'b0;
      end
      if (bus.gnt1) begin
        got = got * 10 + 2;
        c1++;
        if (c1 == 1) begin bus.a1 = 8'd80; bus.b1 = 8'd90; end
        else bus.req1 = 1'b0;
      end
    end
    checks++;
    if (got != 1212) begin
      errors++;
      $display("FAIL fairness_order: grant code=%0d, required 1212", got);
    end
    for (n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fairness_drain: pending=%0d, required 0", sb.size());
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_stale_done();
    test_timeout();
    test_reset_mid_wait();
    test_fairness();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end
endmodule
